// File: rtl/synth_param_pkg.sv
// Shared types and constants for the synthesizer parameter bank.
// Auto-repeat is enabled by defining SYNTH_PARAM_REPEAT_EN.
package synth_param_pkg;

    typedef enum logic [2:0] {
        SEL_AMP = 3'd0,
        SEL_ATK = 3'd1,
        SEL_DEC = 3'd2,
        SEL_SUS = 3'd3,
        SEL_REL = 3'd4
    } sel_e;

    localparam int NUM_ADSR = 5;

    localparam logic [2:0] OCT_MIN   = 3'd0;
    localparam logic [2:0] OCT_MAX   = 3'd7;
    localparam logic [2:0] OCT_RESET = 3'd4;

    // Bit i set means the register addressed by selector i resets to PMAX, clear means 0.
    localparam logic [NUM_ADSR-1:0] ADSR_RESET_MAX = 5'b11011;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    function automatic dir_e decode_dir(input logic plus, input logic minus);
        case ({plus, minus})
            2'b10:   return DIR_UP;
            2'b01:   return DIR_DOWN;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/synth_param_bank_key_repeat.sv
// Turns a level-held plus/minus key pair into single step pulses with optional
// keyboard-style auto-repeat (SYNTH_PARAM_REPEAT_EN).
module key_repeat
    import synth_param_pkg::*;
#(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic plus,
    input  logic minus,
    output logic step,
    output logic step_up
);

    dir_e dir;
    dir_e prev_dir;
    logic new_press;

    assign dir       = decode_dir(plus, minus);
    // A reversal counts as a press just like leaving DIR_NONE.
    assign new_press = (dir != DIR_NONE) && (dir != prev_dir);

    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
        $error("key_repeat: REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

`ifdef SYNTH_PARAM_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    rep_state_e       state;
    logic [CNT_W-1:0] cnt;

    // NOTE: every flop here uses <= so all of them sample pre-edge values;
    // blocking assignments would let later statements see half-updated state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            prev_dir <= DIR_NONE;
            step     <= 1'b0;
            step_up  <= 1'b0;
        end else begin
            prev_dir <= dir;
            step     <= 1'b0;
            if (dir == DIR_NONE) begin
                state <= ST_IDLE;
            end else if (new_press) begin
                step    <= 1'b1;
                step_up <= (dir == DIR_UP);
                state   <= ST_DELAY;
                cnt     <= DELAY_LOAD;
            end else if (state != ST_IDLE) begin
                if (cnt == '0) begin
                    step  <= 1'b1;
                    state <= ST_REPEAT;
                    cnt   <= RATE_LOAD;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end
`else
    // Without auto-repeat the FSM never leaves IDLE: one step per press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_dir <= DIR_NONE;
            step     <= 1'b0;
            step_up  <= 1'b0;
        end else begin
            prev_dir <= dir;
            step     <= new_press;
            if (new_press) begin
                step_up <= (dir == DIR_UP);
            end
        end
    end
`endif

endmodule

// File: rtl/synth_param_bank.sv
// Live synthesizer parameter registers (octave + amplitude/ADSR) with saturating
// stepping from two key_repeat channels; auto-repeat via SYNTH_PARAM_REPEAT_EN.
module synth_param_bank
    import synth_param_pkg::*;
#(
    parameter int          PARAM_W      = 31,
    parameter int unsigned PMAX         = 1073741824,
    parameter int unsigned STEP         = 10,
    parameter int          REPEAT_DELAY = 25000000,
    parameter int          REPEAT_RATE  = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               octave_plus_plus,
    input  logic               octave_minus_minus,
    input  logic [2:0]         ADSR_selector,
    input  logic               ADSR_plus_plus,
    input  logic               ADSR_minus_minus,
    output logic [2:0]         octave,
    output logic [PARAM_W-1:0] amplitude,
    output logic [PARAM_W-1:0] attack,
    output logic [PARAM_W-1:0] decay,
    output logic [PARAM_W-1:0] sustain,
    output logic [PARAM_W-1:0] rel,
    output logic               param_changed
);

    typedef logic [PARAM_W:0] wide_t;

    localparam wide_t              PMAX_W   = wide_t'(PMAX);
    localparam wide_t              STEP_W   = wide_t'(STEP);
    localparam wide_t              UP_LIMIT = PMAX_W - STEP_W;
    localparam logic [PARAM_W-1:0] PMAX_P   = PARAM_W'(PMAX);

    // One extra bit of headroom keeps value+STEP from wrapping before the clamp.
    function automatic logic [PARAM_W-1:0] adsr_next(input logic [PARAM_W-1:0] value,
                                                     input logic up);
        wide_t v;
        wide_t r;
        v = {1'b0, value};
        if (up) begin
            r = (v > UP_LIMIT) ? PMAX_W : v + STEP_W;
        end else begin
            r = (v < STEP_W) ? '0 : v - STEP_W;
        end
        return r[PARAM_W-1:0];
    endfunction

    function automatic logic [2:0] octave_next(input logic [2:0] value, input logic up);
        if (up) begin
            return (value == OCT_MAX) ? value : value + 3'd1;
        end
        return (value == OCT_MIN) ? value : value - 3'd1;
    endfunction

    logic oct_step;
    logic oct_up;
    logic adsr_step;
    logic adsr_up;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_oct_repeat (
        .clk     (clk),
        .reset   (reset),
        .plus    (octave_plus_plus),
        .minus   (octave_minus_minus),
        .step    (oct_step),
        .step_up (oct_up)
    );

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_adsr_repeat (
        .clk     (clk),
        .reset   (reset),
        .plus    (ADSR_plus_plus),
        .minus   (ADSR_minus_minus),
        .step    (adsr_step),
        .step_up (adsr_up)
    );

    logic [2:0]         oct_q;
    logic [2:0]         oct_d;
    logic [PARAM_W-1:0] adsr_q [NUM_ADSR];
    logic [PARAM_W-1:0] adsr_d [NUM_ADSR];
    logic               changed;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        oct_d   = oct_q;
        adsr_d  = adsr_q;
        changed = 1'b0;

        if (oct_step) begin
            oct_d = octave_next(oct_q, oct_up);
        end
        // The selector is sampled when the step lands; 5-7 match nothing.
        if (adsr_step) begin
            for (int i = 0; i < NUM_ADSR; i++) begin
                if (ADSR_selector == 3'(i)) begin
                    adsr_d[i] = adsr_next(adsr_q[i], adsr_up);
                end
            end
        end

        changed = (oct_d != oct_q);
        for (int i = 0; i < NUM_ADSR; i++) begin
            changed = changed | (adsr_d[i] != adsr_q[i]);
        end
    end

    // NOTE: adsr_q is five ordinary flop words rather than a RAM, so giving
    // each entry an asynchronous reset value is cheap and intended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oct_q         <= OCT_RESET;
            param_changed <= 1'b0;
            for (int i = 0; i < NUM_ADSR; i++) begin
                adsr_q[i] <= ADSR_RESET_MAX[i] ? PMAX_P : '0;
            end
        end else begin
            oct_q         <= oct_d;
            param_changed <= changed;
            for (int i = 0; i < NUM_ADSR; i++) begin
                adsr_q[i] <= adsr_d[i];
            end
        end
    end

    assign octave    = oct_q;
    assign amplitude = adsr_q[int'(SEL_AMP)];
    assign attack    = adsr_q[int'(SEL_ATK)];
    assign decay     = adsr_q[int'(SEL_DEC)];
    assign sustain   = adsr_q[int'(SEL_SUS)];
    assign rel       = adsr_q[int'(SEL_REL)];

endmodule
